// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: the instruction-memory request channel, the decode-side IR
// outputs and the execute-side redirect inputs.
interface instr_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request, IR plus a one-entry skid
// buffer for decode stalls, and redirect handling that drops wrong-path responses.
module instr_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [63:0] req_addr, req_addr_n;
  logic [31:0] ir_instr, ir_instr_n;
  logic [63:0] ir_pc, ir_pc_n;
  logic        ir_valid, ir_valid_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [63:0] skid_pc, skid_pc_n;

  logic [63:0] target;
  logic [63:0] pc_inc;
  logic        slot_free;

  assign target    = bus.redirect_pc & ~64'h3;
  assign pc_inc    = pc + 64'd4;
  assign slot_free = !ir_valid || !bus.stall;

  assign bus.imem_req    = (state == REQ) || (state == DROP);
  assign bus.imem_addr   = req_addr;
  assign bus.instr       = ir_instr;
  assign bus.instr_pc    = ir_pc;
  assign bus.instr_valid = ir_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      ir_instr   <= NOP_INSTR;
      ir_pc      <= 64'h0;
      ir_valid   <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 64'h0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_addr   <= req_addr_n;
      ir_instr   <= ir_instr_n;
      ir_pc      <= ir_pc_n;
      ir_valid   <= ir_valid_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
    end
  end

  // Default: a consumed IR empties unless a load below refills it. Redirect is
  // tested first in every state so it beats both stall and IR loads.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_addr_n   = req_addr;
    ir_instr_n   = ir_instr;
    ir_pc_n      = ir_pc;
    ir_valid_n   = ir_valid && bus.stall;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;

    case (state)
      IDLE: begin
        state_n = REQ;
        if (bus.redirect) begin
          pc_n       = target;
          req_addr_n = target;
          ir_valid_n = 1'b0;
        end else begin
          req_addr_n = pc;
        end
      end

      REQ: begin
        if (bus.redirect) begin
          ir_valid_n = 1'b0;
          pc_n       = target;
          if (bus.imem_ack) begin
            req_addr_n = target;
          end else begin
            state_n = DROP;
          end
        end else if (bus.imem_ack) begin
          pc_n = pc_inc;
          if (slot_free) begin
            ir_instr_n = bus.imem_rdata;
            ir_pc_n    = req_addr;
            ir_valid_n = 1'b1;
            req_addr_n = pc_inc;
          end else begin
            skid_instr_n = bus.imem_rdata;
            skid_pc_n    = req_addr;
            state_n      = WAIT;
          end
        end
      end

      WAIT: begin
        if (bus.redirect) begin
          ir_valid_n = 1'b0;
          pc_n       = target;
          req_addr_n = target;
          state_n    = REQ;
        end else if (!bus.stall) begin
          ir_instr_n = skid_instr;
          ir_pc_n    = skid_pc;
          ir_valid_n = 1'b1;
          req_addr_n = pc;
          state_n    = REQ;
        end
      end

      DROP: begin
        // The old request must still complete; its data is thrown away.
        if (bus.redirect) begin
          ir_valid_n = 1'b0;
          pc_n       = target;
        end
        if (bus.imem_ack) begin
          req_addr_n = bus.redirect ? target : pc;
          state_n    = REQ;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a directed vector table, a reset-mid-fetch sequence, and
// a randomized run checked against an instruction-stream reference model.
module tb_instr_fetch;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        stall;
    logic        redirect;
    logic [63:0] rpc;
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [63:0] ipc;
  } vec_t;

  vec_t vecs[19];

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h5EED_1234;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic ack, input logic stall,
                                input logic redirect, input logic [63:0] rpc);
    bus.imem_ack    = ack;
    bus.stall       = stall;
    bus.redirect    = redirect;
    bus.redirect_pc = rpc;
    bus.imem_rdata  = mem_word(bus.imem_addr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " req"},   64'(bus.imem_req), 64'h0);
    check_output({tag, " addr"},  bus.imem_addr, 64'h0);
    check_output({tag, " instr"}, 64'(bus.instr), 64'h13);
    check_output({tag, " ipc"},   bus.instr_pc, 64'h0);
    check_output({tag, " valid"}, 64'(bus.instr_valid), 64'h0);
  endtask

  logic [63:0] exp_pc;
  logic [63:0] prev_addr;
  logic        prev_req;
  logic        prev_ack;
  logic        expect_invalid;
  int          consumed;
  logic        r_ack, r_stall, r_redir;
  logic [63:0] r_rpc;
  logic        s_req, s_valid;
  logic [63:0] s_addr, s_ipc;
  logic [31:0] s_instr;

  initial begin
    vectors     = 0;
    miscompares = 0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 64'h0,    1'b0, 64'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 64'h4,    1'b1, 64'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 64'h8,    1'b1, 64'h4};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 64'h0,    1'b1, 64'hC,    1'b1, 64'h8};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 64'h0,    1'b0, 64'hC,    1'b1, 64'h8};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 64'hC,    1'b1, 64'h8};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 64'hC,    1'b1, 64'h8};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 64'h10,   1'b1, 64'hC};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 64'h10,   1'b0, 64'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 64'h1002, 1'b1, 64'h14,   1'b1, 64'h10};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 64'h0,    1'b1, 64'h14,   1'b0, 64'h0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 64'h14,   1'b0, 64'h0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 64'h2000, 1'b1, 64'h1000, 1'b0, 64'h0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 64'h2000, 1'b0, 64'h0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 64'h200,  1'b1, 64'h2004, 1'b1, 64'h2000};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 64'h300,  1'b1, 64'h2004, 1'b0, 64'h0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 64'h2004, 1'b0, 64'h0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 64'h300,  1'b0, 64'h0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 64'h304,  1'b1, 64'h300};

    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.stall = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 64'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Table phase: observe outputs, then drive the inputs for the next edge.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      check_output($sformatf("v%0d req", i),   64'(bus.imem_req), 64'(vecs[i].req));
      check_output($sformatf("v%0d addr", i),  bus.imem_addr, vecs[i].addr);
      check_output($sformatf("v%0d valid", i), 64'(bus.instr_valid), 64'(vecs[i].valid));
      if (vecs[i].valid) begin
        check_output($sformatf("v%0d ipc", i),   bus.instr_pc, vecs[i].ipc);
        check_output($sformatf("v%0d instr", i), 64'(bus.instr), 64'(mem_word(vecs[i].ipc)));
      end
      apply_stimulus(vecs[i].ack, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
    end

    // Reset while a request is pending, with acks arriving during and after it.
    @(negedge clk);
    check_output("pre-reset req", 64'(bus.imem_req), 64'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0);
    repeat (2) begin
      @(negedge clk);
      check_output("inreset req", 64'(bus.imem_req), 64'h0);
    end
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    check_output("postreset req",   64'(bus.imem_req), 64'h1);
    check_output("postreset addr",  bus.imem_addr, 64'h0);
    check_output("postreset valid", 64'(bus.instr_valid), 64'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    check_output("postreset ipc",   bus.instr_pc, 64'h0);
    check_output("postreset valid1", 64'(bus.instr_valid), 64'h1);
    check_output("postreset addr4", bus.imem_addr, 64'h4);

    // Randomized phase: the model is the expected sequence of consumed PCs.
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 64'h0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 64'h0;
    expect_invalid = 1'b0;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      s_req = bus.imem_req; s_addr = bus.imem_addr; s_valid = bus.instr_valid;
      s_ipc = bus.instr_pc; s_instr = bus.instr;
      if (expect_invalid) check_output("rnd valid after redirect", 64'(s_valid), 64'h0);
      if (prev_req && !prev_ack) begin
        check_output("rnd req held", 64'(s_req), 64'h1);
        check_output("rnd addr stable", s_addr, prev_addr);
      end
      r_stall = ($urandom_range(9) < 3);
      r_ack   = ($urandom_range(9) < 6);
      r_redir = ($urandom_range(99) < 3);
      r_rpc   = {$urandom, $urandom};
      if (s_valid && !r_stall && !r_redir) begin
        check_output("rnd consumed pc", s_ipc, exp_pc);
        check_output("rnd consumed instr", 64'(s_instr), 64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        consumed++;
      end
      if (r_redir) exp_pc = r_rpc & ~64'h3;
      expect_invalid = r_redir;
      prev_req = s_req; prev_addr = s_addr; prev_ack = r_ack;
      apply_stimulus(r_ack, r_stall, r_redir, r_rpc);
    end
    check_output("rnd progress", 64'(consumed >= 300), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
